nn_scale_engine: RTL

Parametrised nearest-neighbour scaling engine that copies a SRC_W×SRC_H image from a synchronous source ROM into a DST_W×DST_H framebuffer RAM. It supports a runtime integer zoom factor, centres the image automatically and optionally fills the surrounding border with a background colour. It runs under a start/done handshake so the display controller can re-render on a zoom change without a reset. It sits between the image ROM and the VGA framebuffer write port.

---
 rtl/nn_scale_engine.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/nn_scale_engine.sv
// Nearest-neighbour scaling engine: copies a SRC_W x SRC_H image from a synchronous ROM into a
// DST_W x DST_H framebuffer at integer zoom Z, centred, with an optional BG_COLOR border fill.
// Latency: start-to-done = 1 + (clear_en ? DST_W*DST_H : 0) + SRC_W*SRC_H*(1+ROM_LAT+Z*Z) cycles.
// Backpressure: none; the framebuffer port accepts one write per ram_wren cycle. start is ignored while busy.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start/zoom/clear_en  render request; zoom and clear_en are latched when start is accepted in IDLE
//   rom_addr/rom_data source ROM; rom_data must hold the addressed pixel on the ROM_LAT-th edge
//                     after rom_addr changes
//   ram_addr/ram_data/ram_wren  framebuffer write port, one write per cycle with ram_wren high
//   busy/done/err     status: render in progress, one-cycle completion pulse, one-cycle reject pulse
module nn_scale_engine #(
  parameter int SRC_W    = 160,
  parameter int SRC_H    = 120,
  parameter int DST_W    = 640,
  parameter int DST_H    = 480,
  parameter int PIX_W    = 8,
  parameter int MAX_ZOOM = 4,
  parameter int ROM_LAT  = 1,
  parameter logic [PIX_W-1:0] BG_COLOR = '0,
  localparam int SA_W = $clog2(SRC_W*SRC_H),
  localparam int DA_W = $clog2(DST_W*DST_H),
  localparam int Z_W  = $clog2(MAX_ZOOM+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [Z_W-1:0]   zoom,
  input  logic             clear_en,
  output logic [SA_W-1:0]  rom_addr,
  input  logic [PIX_W-1:0] rom_data,
  output logic [DA_W-1:0]  ram_addr,
  output logic [PIX_W-1:0] ram_data,
  output logic             ram_wren,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int XW   = $clog2(DST_W+1);
  localparam int YW   = $clog2(DST_H+1);
  localparam int SX_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int SY_W = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam int WC_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [DA_W-1:0] LAST_DA  = DA_W'(DST_W*DST_H-1);
  localparam logic [DA_W-1:0] ROW_STEP = DA_W'(DST_W);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT, WRITE, DONE} state_t;
  state_t state;

  logic [Z_W-1:0]  z_reg, dx, dy;
  logic [XW-1:0]   x0, x1, cx;
  logic [YW-1:0]   y0, y1, cy;
  logic [SX_W-1:0] sx;
  logic [SY_W-1:0] sy;
  logic [SA_W-1:0] src_idx;
  logic [DA_W-1:0] row_base, pix_base, line_addr, zrow;
  logic [WC_W-1:0] wcnt;

  // Decode of the zoom request, only meaningful in IDLE. Computed at integer width so an
  // oversize zoom cannot wrap into an apparently valid window.
  int zi, offx, offy;
  logic z_ok;
  logic [XW-1:0]   c_x0, c_x1;
  logic [YW-1:0]   c_y0, c_y1;
  logic [DA_W-1:0] c_base, c_zrow;

  always_comb begin
    zi     = int'(zoom);
    offx   = (DST_W - SRC_W*zi) / 2;
    offy   = (DST_H - SRC_H*zi) / 2;
    z_ok   = (zi >= 1) && (zi <= MAX_ZOOM) && (SRC_W*zi <= DST_W) && (SRC_H*zi <= DST_H);
    c_x0   = XW'(offx);
    c_x1   = XW'(offx + SRC_W*zi);
    c_y0   = YW'(offy);
    c_y1   = YW'(offy + SRC_H*zi);
    c_base = DA_W'(offy*DST_W + offx);
    c_zrow = DA_W'(zi*DST_W);
  end

  // Next raster position of the border scan.
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;

  always_comb begin
    if (cx == XW'(DST_W-1)) begin
      nx = '0;
      ny = cy + 1'b1;
    end else begin
      nx = cx + 1'b1;
      ny = cy;
    end
  end

  function automatic logic outside(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                   input logic [XW-1:0] xa, input logic [XW-1:0] xb,
                                   input logic [YW-1:0] ya, input logic [YW-1:0] yb);
    return (x < xa) || (x >= xb) || (y < ya) || (y >= yb);
  endfunction

  // Write-port outputs are loaded one edge ahead so every write is presented exactly during
  // its CLEAR/WRITE cycle; ram_data doubles as the captured source pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rom_addr  <= '0;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_wren  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      z_reg     <= '0;
      dx        <= '0;
      dy        <= '0;
      x0        <= '0;
      x1        <= '0;
      y0        <= '0;
      y1        <= '0;
      cx        <= '0;
      cy        <= '0;
      sx        <= '0;
      sy        <= '0;
      src_idx   <= '0;
      row_base  <= '0;
      pix_base  <= '0;
      line_addr <= '0;
      zrow      <= '0;
      wcnt      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!z_ok) begin
              err <= 1'b1;
            end else begin
              z_reg    <= zoom;
              x0       <= c_x0;
              x1       <= c_x1;
              y0       <= c_y0;
              y1       <= c_y1;
              row_base <= c_base;
              pix_base <= c_base;
              zrow     <= c_zrow;
              sx       <= '0;
              sy       <= '0;
              src_idx  <= '0;
              busy     <= 1'b1;
              if (clear_en) begin
                state    <= CLEAR;
                cx       <= '0;
                cy       <= '0;
                ram_addr <= '0;
                ram_data <= BG_COLOR;
                ram_wren <= outside('0, '0, c_x0, c_x1, c_y0, c_y1);
              end else begin
                state <= FETCH;
              end
            end
          end
        end

        CLEAR: begin
          if (ram_addr == LAST_DA) begin
            ram_wren <= 1'b0;
            state    <= FETCH;
          end else begin
            cx       <= nx;
            cy       <= ny;
            ram_addr <= ram_addr + 1'b1;
            ram_wren <= outside(nx, ny, x0, x1, y0, y1);
          end
        end

        FETCH: begin
          rom_addr <= src_idx;
          wcnt     <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (wcnt == WC_W'(ROM_LAT-1)) begin
            ram_data  <= rom_data;
            ram_addr  <= pix_base;
            line_addr <= pix_base;
            dx        <= '0;
            dy        <= '0;
            ram_wren  <= 1'b1;
            state     <= WRITE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        WRITE: begin
          if (dx == z_reg - 1'b1) begin
            if (dy == z_reg - 1'b1) begin
              // Last sub-pixel of this source pixel: step to the next one.
              ram_wren <= 1'b0;
              src_idx  <= src_idx + 1'b1;
              if (sx == SX_W'(SRC_W-1)) begin
                sx <= '0;
                if (sy == SY_W'(SRC_H-1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
                end else begin
                  sy       <= sy + 1'b1;
                  row_base <= row_base + zrow;
                  pix_base <= row_base + zrow;
                  state    <= FETCH;
                end
              end else begin
                sx       <= sx + 1'b1;
                pix_base <= pix_base + DA_W'(z_reg);
                state    <= FETCH;
              end
            end else begin
              dy        <= dy + 1'b1;
              dx        <= '0;
              line_addr <= line_addr + ROW_STEP;
              ram_addr  <= line_addr + ROW_STEP;
            end
          end else begin
            dx       <= dx + 1'b1;
            ram_addr <= ram_addr + 1'b1;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
